// File: rtl/lsu_issue.sv
// In-order issue buffer between dispatch and the LSU: a small FIFO of packed
// execution parameters, with store issue gated on commit credits and fences held until the LSU drains.

`ifndef LSU_EXEPARAM_DW
`define LSU_EXEPARAM_DW 32
`endif

module lsu_issue #(
  parameter int DW = `LSU_EXEPARAM_DW,
  parameter int DP = 4,
  parameter int AW = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          dispat_vaild,
  output logic          dispat_ready,
  input  logic [DW-1:0] dispat_param,
  input  logic          commit_store_vaild,
  output logic          lsu_exeparam_vaild,
  input  logic          lsu_exeparam_ready,
  output logic [DW-1:0] lsu_exeparam,
  input  logic          lsu_writeback_vaild,
  input  logic          flush
);

  typedef struct packed {
    logic [DW-1:0] param;
    logic          is_store;
    logic          is_fence;
  } entry_t;

  entry_t      mem [DP];
  entry_t      head;
  entry_t      incoming;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [1:0]  scred;
  logic [1:0]  outs;
  logic        full;
  logic        empty;
  logic        eligible;
  logic        push;
  logic        issue;
  logic        store_issue;

  // Opcode one-hots sit at the top of the parameter: sb..sd, then fence_i, fence.
  assign incoming.param    = dispat_param;
  assign incoming.is_store = |dispat_param[DW-8 -: 4];
  assign incoming.is_fence = |dispat_param[DW-12 -: 2];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    // NOTE: default first so every path assigns eligible and no latch is inferred.
    eligible = 1'b0;
    if (!empty && !flush) begin
      if (head.is_fence)      eligible = (outs == 2'd0);
      else if (head.is_store) eligible = (scred != 2'd0) && (outs != 2'd3);
      else                    eligible = (outs != 2'd3);
    end
  end

  assign dispat_ready       = ~full;
  assign lsu_exeparam_vaild = eligible;
  assign lsu_exeparam       = empty ? '0 : head.param;

  assign push        = dispat_vaild & dispat_ready & ~flush & ~RST;
  assign issue       = eligible & lsu_exeparam_ready & ~RST;
  assign store_issue = issue & head.is_store;

  // NOTE: payload storage has no reset; it is only observed through the head while non-empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= incoming;
  end

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      scred  <= 2'd0;
      outs   <= 2'd0;
    end else begin
      if (flush) begin
        // The LSU drops flushed writebacks, so outstanding work is forgotten too.
        wr_ptr <= '0;
        rd_ptr <= '0;
        outs   <= 2'd0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        case ({issue, lsu_writeback_vaild})
          2'b10:   outs <= outs + 2'd1;
          2'b01:   outs <= outs - 2'd1;
          default: outs <= outs;
        endcase
      end
      // Credits survive a flush: committed stores must still reach memory.
      case ({commit_store_vaild, store_issue})
        2'b10:   scred <= scred + 2'd1;
        2'b01:   scred <= scred - 2'd1;
        default: scred <= scred;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_issue.sv
// Self-checking bench for lsu_issue: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a queue-based reference model.

module tb_lsu_issue;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          dispat_vaild;
  logic          dispat_ready;
  logic [DW-1:0] dispat_param;
  logic          commit_store_vaild;
  logic          lsu_exeparam_vaild;
  logic          lsu_exeparam_ready;
  logic [DW-1:0] lsu_exeparam;
  logic          lsu_writeback_vaild;
  logic          flush;

  lsu_issue #(.DW(DW), .DP(DP), .AW(AW)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .dispat_vaild        (dispat_vaild),
    .dispat_ready        (dispat_ready),
    .dispat_param        (dispat_param),
    .commit_store_vaild  (commit_store_vaild),
    .lsu_exeparam_vaild  (lsu_exeparam_vaild),
    .lsu_exeparam_ready  (lsu_exeparam_ready),
    .lsu_exeparam        (lsu_exeparam),
    .lsu_writeback_vaild (lsu_writeback_vaild),
    .flush               (flush)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Opcode indices counted from the MSB of the parameter.
  localparam int LW = 2, LD = 3, SB = 7, SD = 10, FENCE = 12;

  function automatic logic [DW-1:0] op(input int idx, input int payload);
    logic [DW-1:0] p;
    p = '0;
    p[DW-1-idx] = 1'b1;
    p[15:0] = payload[15:0];
    return p;
  endfunction

  // ---------------- reference model ----------------
  typedef enum {K_LOAD, K_STORE, K_FENCE} kind_e;
  typedef struct {
    logic [DW-1:0] param;
    kind_e         kind;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_cred = 0;
  int     m_outs = 0;

  function automatic kind_e classify(input logic [DW-1:0] p);
    if (p[DW-12] || p[DW-13]) return K_FENCE;
    if (p[DW-8] || p[DW-9] || p[DW-10] || p[DW-11]) return K_STORE;
    return K_LOAD;
  endfunction

  function automatic bit m_elig();
    if (m_q.size() == 0 || flush) return 1'b0;
    case (m_q[0].kind)
      K_LOAD:  return m_outs < 3;
      K_STORE: return m_cred > 0 && m_outs < 3;
      default: return m_outs == 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] m_head();
    if (m_q.size() == 0) return '0;
    return m_q[0].param;
  endfunction

  task automatic model_check();
    check("m_dready", dispat_ready, m_q.size() < DP);
    check("m_vaild", lsu_exeparam_vaild, m_elig());
    check("m_param", lsu_exeparam, m_head());
    check("m_scred", dut.scred, m_cred);
    check("m_outs", dut.outs, m_outs);
  endtask

  task automatic model_update();
    bit iss;
    bit psh;
    m_ent_t e;
    iss = m_elig() && lsu_exeparam_ready;
    psh = dispat_vaild && (m_q.size() < DP) && !flush;
    assert (RST || !commit_store_vaild || m_cred < 3);
    if (RST) begin
      m_q.delete();
      m_cred = 0;
      m_outs = 0;
    end else if (flush) begin
      m_q.delete();
      m_outs = 0;
      if (commit_store_vaild) m_cred++;
    end else begin
      if (iss) begin
        if (m_q[0].kind == K_STORE) m_cred--;
        void'(m_q.pop_front());
        m_outs++;
      end
      if (commit_store_vaild) m_cred++;
      if (lsu_writeback_vaild) m_outs--;
      if (psh) begin
        e.param = dispat_param;
        e.kind  = classify(dispat_param);
        m_q.push_back(e);
      end
    end
  endtask

  task automatic to_neg(input bit chk);
    @(negedge CLK);
    if (chk) model_check();
  endtask

  task automatic to_pos();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic drive(input bit dv, input logic [DW-1:0] p, input bit cm,
                       input bit rdy, input bit wb, input bit fl);
    RST                 = 1'b0;
    dispat_vaild        = dv;
    dispat_param        = p;
    commit_store_vaild  = cm;
    lsu_exeparam_ready  = rdy;
    lsu_writeback_vaild = wb;
    flush               = fl;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rst;
    bit            dv;
    logic [DW-1:0] param;
    bit            rdy;
    bit            wb;
    bit            e_dready;
    bit            e_vaild;
    logic [DW-1:0] e_param;
  } vec_t;

  function automatic vec_t mkv(input bit rst, input bit dv, input logic [DW-1:0] p,
                               input bit rdy, input bit wb, input bit e_dr,
                               input bit e_v, input logic [DW-1:0] e_p);
    vec_t v;
    v.rst = rst; v.dv = dv; v.param = p; v.rdy = rdy; v.wb = wb;
    v.e_dready = e_dr; v.e_vaild = e_v; v.e_param = e_p;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    logic [DW-1:0] l1, l2, l3, l4, l5, l6, l7, l8, l9, z;
    logic [DW-1:0] s_sd, s_lw, f_a, f_fn, f_b, fl1, fl2, fl3, fl4, fl5, s_sb;
    z  = '0;
    l1 = op(LD, 16'h0001); l2 = op(LD, 16'h0002); l3 = op(LD, 16'h0003);
    l4 = op(LD, 16'h0004); l5 = op(LD, 16'h0105); l6 = op(LD, 16'h0106);
    l7 = op(LD, 16'h0107); l8 = op(LD, 16'h0108); l9 = op(LD, 16'h0109);

    //                 rst dv param rdy wb  dready vaild param
    vecs[0]  = mkv(1, 1, l9, 0, 0, 1, 0, z);   // reset held, dispatch offered
    vecs[1]  = mkv(0, 0, z,  0, 0, 1, 0, z);   // nothing was pushed during reset
    vecs[2]  = mkv(0, 0, z,  0, 0, 1, 0, z);
    vecs[3]  = mkv(0, 1, l1, 1, 0, 1, 0, z);   // load stream
    vecs[4]  = mkv(0, 1, l2, 1, 0, 1, 1, l1);
    vecs[5]  = mkv(0, 1, l3, 1, 1, 1, 1, l2);
    vecs[6]  = mkv(0, 1, l4, 1, 1, 1, 1, l3);
    vecs[7]  = mkv(0, 0, z,  1, 1, 1, 1, l4);
    vecs[8]  = mkv(0, 0, z,  0, 1, 1, 0, z);
    vecs[9]  = mkv(0, 1, l5, 0, 0, 1, 0, z);   // fill to full
    vecs[10] = mkv(0, 1, l6, 0, 0, 1, 1, l5);
    vecs[11] = mkv(0, 1, l7, 0, 0, 1, 1, l5);
    vecs[12] = mkv(0, 1, l8, 0, 0, 1, 1, l5);
    vecs[13] = mkv(0, 1, l9, 0, 0, 0, 1, l5);  // fifth refused
    vecs[14] = mkv(0, 1, l9, 1, 0, 0, 1, l5);  // pop cycle: still not ready
    vecs[15] = mkv(0, 1, l9, 0, 1, 1, 1, l6);  // slot reopens, fifth accepted
    vecs[16] = mkv(0, 0, z,  1, 0, 0, 1, l6);
    vecs[17] = mkv(0, 0, z,  1, 1, 1, 1, l7);
    vecs[18] = mkv(0, 0, z,  1, 1, 1, 1, l8);
    vecs[19] = mkv(0, 0, z,  1, 1, 1, 1, l9);
    vecs[20] = mkv(0, 0, z,  0, 1, 1, 0, z);

    // First reset edge brings state out of X.
    drive(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    dispat_vaild = 1'b1;
    dispat_param = l9;
    to_neg(1'b0);
    to_pos();

    foreach (vecs[i]) begin
      drive(vecs[i].dv, vecs[i].param, 1'b0, vecs[i].rdy, vecs[i].wb, 1'b0);
      RST = vecs[i].rst;
      to_neg(1'b1);
      check($sformatf("v%0d_dready", i), dispat_ready, vecs[i].e_dready);
      check($sformatf("v%0d_vaild", i), lsu_exeparam_vaild, vecs[i].e_vaild);
      check($sformatf("v%0d_param", i), lsu_exeparam, vecs[i].e_param);
      to_pos();
    end

    // ---------------- store gating ----------------
    s_sd = op(SD, 16'h0a0a);
    s_lw = op(LW, 16'h0b0b);
    drive(1'b1, s_sd, 1'b0, 1'b1, 1'b0, 1'b0); to_neg(1'b1); to_pos();
    drive(1'b1, s_lw, 1'b0, 1'b1, 1'b0, 1'b0); to_neg(1'b1); to_pos();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0);
      to_neg(1'b1);
      check("st_blocked", lsu_exeparam_vaild, 1'b0);
      to_pos();
    end
    drive(1'b0, z, 1'b1, 1'b1, 1'b0, 1'b0);
    to_neg(1'b1);
    check("st_credit_cycle", lsu_exeparam_vaild, 1'b0);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0);
    to_neg(1'b1);
    check("st_sd_vaild", lsu_exeparam_vaild, 1'b1);
    check("st_sd_param", lsu_exeparam, s_sd);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b1, 1'b1, 1'b0);
    to_neg(1'b1);
    check("st_lw_vaild", lsu_exeparam_vaild, 1'b1);
    check("st_lw_param", lsu_exeparam, s_lw);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0);
    to_neg(1'b1);
    check("st_scred_zero", dut.scred, 2'd0);
    to_pos();

    // ---------------- fence ----------------
    f_a  = op(LW, 16'h0c01);
    f_fn = op(FENCE, 16'h0c02);
    f_b  = op(LW, 16'h0c03);
    drive(1'b1, f_a, 1'b0, 1'b1, 1'b0, 1'b0); to_neg(1'b1); to_pos();
    drive(1'b1, f_fn, 1'b0, 1'b1, 1'b0, 1'b0);
    to_neg(1'b1);
    check("fn_lw_a", lsu_exeparam, f_a);
    to_pos();
    drive(1'b1, f_b, 1'b0, 1'b1, 1'b0, 1'b0);
    to_neg(1'b1);
    check("fn_wait0", lsu_exeparam_vaild, 1'b0);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0);
    to_neg(1'b1);
    check("fn_wait1", lsu_exeparam_vaild, 1'b0);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b1, 1'b1, 1'b0);
    to_neg(1'b1);
    check("fn_wait_wb", lsu_exeparam_vaild, 1'b0);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0);
    to_neg(1'b1);
    check("fn_issue_vaild", lsu_exeparam_vaild, 1'b1);
    check("fn_issue_param", lsu_exeparam, f_fn);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b1, 1'b1, 1'b0);
    to_neg(1'b1);
    check("fn_lw_b_vaild", lsu_exeparam_vaild, 1'b1);
    check("fn_lw_b_param", lsu_exeparam, f_b);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0); to_neg(1'b1); to_pos();

    // ---------------- flush ----------------
    fl1 = op(LD, 16'h0d01); fl2 = op(LD, 16'h0d02); fl3 = op(LD, 16'h0d03);
    fl4 = op(LD, 16'h0d04); fl5 = op(LD, 16'h0d05); s_sb = op(SB, 16'h0d06);
    drive(1'b1, fl1, 1'b0, 1'b0, 1'b0, 1'b0); to_neg(1'b1); to_pos();
    drive(1'b1, fl2, 1'b0, 1'b0, 1'b0, 1'b0); to_neg(1'b1); to_pos();
    drive(1'b1, fl3, 1'b0, 1'b1, 1'b0, 1'b0); to_neg(1'b1); to_pos();
    drive(1'b1, fl4, 1'b1, 1'b0, 1'b0, 1'b0);
    to_neg(1'b1);
    to_pos();
    drive(1'b1, fl5, 1'b0, 1'b1, 1'b0, 1'b1);
    to_neg(1'b1);
    check("fl_pre_outs", dut.outs, 2'd1);
    check("fl_pre_scred", dut.scred, 2'd1);
    check("fl_vaild_gated", lsu_exeparam_vaild, 1'b0);
    to_pos();
    drive(1'b1, s_sb, 1'b0, 1'b0, 1'b0, 1'b0);
    to_neg(1'b1);
    check("fl_empty_param", lsu_exeparam, z);
    check("fl_empty_vaild", lsu_exeparam_vaild, 1'b0);
    check("fl_outs", dut.outs, 2'd0);
    check("fl_scred", dut.scred, 2'd1);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0);
    to_neg(1'b1);
    check("fl_sb_vaild", lsu_exeparam_vaild, 1'b1);
    check("fl_sb_param", lsu_exeparam, s_sb);
    to_pos();
    drive(1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0);
    to_neg(1'b1);
    check("fl_scred_used", dut.scred, 2'd0);
    to_pos();

    // ---------------- randomized run ----------------
    for (int n = 0; n < 3000; n++) begin
      bit fl;
      fl = ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 99) < 60,
            op($urandom_range(0, 12), $urandom),
            !fl && (m_cred < 3) && ($urandom_range(0, 99) < 30),
            $urandom_range(0, 99) < 70,
            (m_outs > 0) && ($urandom_range(0, 99) < 60),
            fl);
      RST = ($urandom_range(0, 199) == 0);
      to_neg(1'b1);
      to_pos();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_issue.md
# lsu_issue

In-order issue buffer for the load/store unit. Accepts load, store and fence operations from dispatch, holds them in a FIFO, and feeds them one at a time to the LSU over the `lsu_exeparam` vaild/ready handshake. It gates stores on commit credits from the reorder buffer and holds fences until the LSU has drained. It sits between dispatch/operand read and the LSU execute stage.

## Interface
- `DW`, default `` `LSU_EXEPARAM_DW ``: width of one packed LSU execution parameter.
- `DP`, default 4: FIFO depth in entries; must be a power of 2.
- `AW`, default 2: pointer width, equal to log2(`DP`).

Ports:
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `dispat_vaild` in 1: dispatch offers an operation.
- `dispat_ready` out 1: buffer can accept an operation.
- `dispat_param` in DW: packed execution parameter, in the same layout the LSU consumes.
- `commit_store_vaild` in 1: one-cycle pulse; grants one store credit.
- `lsu_exeparam_vaild` out 1: head entry is eligible to issue.
- `lsu_exeparam_ready` in 1: LSU accepts the operation this cycle.
- `lsu_exeparam` out DW: head entry parameter, passed through unmodified.
- `lsu_writeback_vaild` in 1: LSU completed one operation.
- `flush` in 1: pipeline flush.

## Operation
- **Parameter layout.** The top 13 bits of the parameter, MSB first, are lb, lh, lw, ld, lbu, lhu, lwu, sb, sh, sw, sd, fence_i, fence.
  - isStore = `dispat_param[DW-8] | [DW-9] | [DW-10] | [DW-11]`.
  - isFence = `[DW-12] | [DW-13]`.
  - Everything else is a load.
- **FIFO.** `DP` entries. Each entry holds the param plus the isStore and isFence flags.
  - Read and write pointers are `AW+1` bits wide (extra wrap bit).
  - full = same index with differing wrap bit; empty = pointers equal.
  - Pointers wrap modulo 2·`DP`.
- **Dispatch handshake.** `dispat_ready = ~full`. It does not depend on a same-cycle pop.
  - A push occurs when `dispat_vaild & dispat_ready & ~flush`.
- **Store credits.** 2-bit counter `scred`.
  - +1 on `commit_store_vaild`.
  - −1 when a store issues.
  - Both in the same cycle leave it unchanged.
  - Increment past 3 is illegal; the bench asserts on it.
- **Outstanding counter.** 2-bit counter `outs`.
  - +1 on issue handshake.
  - −1 on `lsu_writeback_vaild`.
  - Both in the same cycle leave it unchanged.
- **Head eligibility** (`lsu_exeparam_vaild`): ~empty & ~flush, and
  - load: `outs != 3`;
  - store: `scred != 0` & `outs != 3`;
  - fence: `outs == 0`.
- **Issue.** An issue occurs when `lsu_exeparam_vaild & lsu_exeparam_ready`; the head pops.
  - `lsu_exeparam` = head param whenever ~empty. When empty it is don't-care; the implementation drives 0.
- **Flush.** Empties the FIFO (both pointers to 0) and clears `outs` to 0, because the LSU drops flushed writebacks.
  - `scred` is preserved: committed stores still must issue.
  - Flush has priority over push and pop in the same cycle.
  - No dispatch or issue handshake completes in a flush cycle.
- **Reset.** Pointers, `scred` and `outs` go to 0.
  - After reset: `dispat_ready=1`, `lsu_exeparam_vaild=0`, `lsu_exeparam=0`.
  - Entry payload storage is not reset.

## Timing
- **Dispatch to issue latency.** An entry pushed at edge N is at the head and may issue from cycle N+1 at the earliest. There is no bypass.
- **Combinational outputs.** `lsu_exeparam_vaild` and `lsu_exeparam` are combinational from registered state plus `flush`. There is no path from `lsu_exeparam_ready` to `lsu_exeparam_vaild`.
- **Throughput.** One issue per cycle while eligible.
  - With the 1-cycle LSU, `outs` toggles 0↔1 and loads stream back-to-back.
- **Fence at head.** Waits until `outs == 0`. It then issues and counts as outstanding like any other operation.
- **Credit timing.** A credit pulse at edge N allows a head store to issue in cycle N+1.
- **Full with simultaneous pop.** When full, `dispat_ready` is 0 even if the head pops that cycle. The slot reopens next cycle.
- **Reset mid-operation.** Reset in any cycle discards all entries and credits. No handshake completes in that cycle.

## Test plan
1. **Reset.** Hold `RST` 2 cycles with `dispat_vaild=1` → `dispat_ready=1`, `lsu_exeparam_vaild=0`, no push occurs. After release, outputs stay quiet until the first push.
2. **Load stream.** 4 ld ops pushed on consecutive cycles; `lsu_exeparam_ready=1`; writeback 1 cycle after each issue → issues on cycles 1–4 in order with params bit-identical; `outs` ends at 0.
3. **Full.** 5 pushes, `lsu_exeparam_ready=0` → the first 4 accepted, `dispat_ready=0` on the 5th.
   - Raise ready → the 5th is accepted one cycle after the first pop, not in the pop cycle.
4. **Store gating.** Push sd then lw, no credit → `lsu_exeparam_vaild=0` for 10 cycles and the lw stays blocked behind it.
   - Pulse `commit_store_vaild` → sd issues the next cycle, lw the cycle after; `scred` returns to 0.
5. **Fence.** Push lw, fence, lw; LSU writeback delayed 3 cycles after the first lw → the fence issues only in the cycle after that writeback. The second lw follows.
6. **Flush.** 3 entries queued, `scred=1`, `outs=1`; assert flush with simultaneous `dispat_vaild` and `lsu_exeparam_ready` → nothing pushed or issued.
   - Next cycle: empty, `outs=0`, `scred=1`.
   - A subsequently pushed sb issues immediately using the retained credit.
